rom: RTL and testbench

ROM -- requirements
Module: rom

---
 rtl/rom.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_rom.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rom.sv
// 256 x 8 read-only lookup with a registered output.
// Each word is the nibble-swapped address XOR 8'h5A, stored as a constant table.
module rom (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic [7:0] Address,
    output logic [7:0] Out
);

    logic [7:0] rom_d;
    logic [7:0] out_q;

    function automatic logic [7:0] rom_lookup(input logic [7:0] addr);
        rom_lookup = 8'h00;
        case (addr)
            8'h00: rom_lookup = 8'h5A;
            8'h01: rom_lookup = 8'h4A;
            8'h02: rom_lookup = 8'h7A;
            8'h03: rom_lookup = 8'h6A;
            8'h04: rom_lookup = 8'h1A;
            8'h05: rom_lookup = 8'h0A;
            8'h06: rom_lookup = 8'h3A;
            8'h07: rom_lookup = 8'h2A;
            8'h08: rom_lookup = 8'hDA;
            8'h09: rom_lookup = 8'hCA;
            8'h0A: rom_lookup = 8'hFA;
            8'h0B: rom_lookup = 8'hEA;
            8'h0C: rom_lookup = 8'h9A;
            8'h0D: rom_lookup = 8'h8A;
            8'h0E: rom_lookup = 8'hBA;
            8'h0F: rom_lookup = 8'hAA;
            8'h10: rom_lookup = 8'h5B;
            8'h11: rom_lookup = 8'h4B;
            8'h12: rom_lookup = 8'h7B;
            8'h13: rom_lookup = 8'h6B;
            8'h14: rom_lookup = 8'h1B;
            8'h15: rom_lookup = 8'h0B;
            8'h16: rom_lookup = 8'h3B;
            8'h17: rom_lookup = 8'h2B;
            8'h18: rom_lookup = 8'hDB;
            8'h19: rom_lookup = 8'hCB;
            8'h1A: rom_lookup = 8'hFB;
            8'h1B: rom_lookup = 8'hEB;
            8'h1C: rom_lookup = 8'h9B;
            8'h1D: rom_lookup = 8'h8B;
            8'h1E: rom_lookup = 8'hBB;
            8'h1F: rom_lookup = 8'hAB;
            8'h20: rom_lookup = 8'h58;
            8'h21: rom_lookup = 8'h48;
            8'h22: rom_lookup = 8'h78;
            8'h23: rom_lookup = 8'h68;
            8'h24: rom_lookup = 8'h18;
            8'h25: rom_lookup = 8'h08;
            8'h26: rom_lookup = 8'h38;
            8'h27: rom_lookup = 8'h28;
            8'h28: rom_lookup = 8'hD8;
            8'h29: rom_lookup = 8'hC8;
            8'h2A: rom_lookup = 8'hF8;
            8'h2B: rom_lookup = 8'hE8;
            8'h2C: rom_lookup = 8'h98;
            8'h2D: rom_lookup = 8'h88;
            8'h2E: rom_lookup = 8'hB8;
            8'h2F: rom_lookup = 8'hA8;
            8'h30: rom_lookup = 8'h59;
            8'h31: rom_lookup = 8'h49;
            8'h32: rom_lookup = 8'h79;
            8'h33: rom_lookup = 8'h69;
            8'h34: rom_lookup = 8'h19;
            8'h35: rom_lookup = 8'h09;
            8'h36: rom_lookup = 8'h39;
            8'h37: rom_lookup = 8'h29;
            8'h38: rom_lookup = 8'hD9;
            8'h39: rom_lookup = 8'hC9;
            8'h3A: rom_lookup = 8'hF9;
            8'h3B: rom_lookup = 8'hE9;
            8'h3C: rom_lookup = 8'h99;
            8'h3D: rom_lookup = 8'h89;
            8'h3E: rom_lookup = 8'hB9;
            8'h3F: rom_lookup = 8'hA9;
            8'h40: rom_lookup = 8'h5E;
            8'h41: rom_lookup = 8'h4E;
            8'h42: rom_lookup = 8'h7E;
            8'h43: rom_lookup = 8'h6E;
            8'h44: rom_lookup = 8'h1E;
            8'h45: rom_lookup = 8'h0E;
            8'h46: rom_lookup = 8'h3E;
            8'h47: rom_lookup = 8'h2E;
            8'h48: rom_lookup = 8'hDE;
            8'h49: rom_lookup = 8'hCE;
            8'h4A: rom_lookup = 8'hFE;
            8'h4B: rom_lookup = 8'hEE;
            8'h4C: rom_lookup = 8'h9E;
            8'h4D: rom_lookup = 8'h8E;
            8'h4E: rom_lookup = 8'hBE;
            8'h4F: rom_lookup = 8'hAE;
            8'h50: rom_lookup = 8'h5F;
            8'h51: rom_lookup = 8'h4F;
            8'h52: rom_lookup = 8'h7F;
            8'h53: rom_lookup = 8'h6F;
            8'h54: rom_lookup = 8'h1F;
            8'h55: rom_lookup = 8'h0F;
            8'h56: rom_lookup = 8'h3F;
            8'h57: rom_lookup = 8'h2F;
            8'h58: rom_lookup = 8'hDF;
            8'h59: rom_lookup = 8'hCF;
            8'h5A: rom_lookup = 8'hFF;
            8'h5B: rom_lookup = 8'hEF;
            8'h5C: rom_lookup = 8'h9F;
            8'h5D: rom_lookup = 8'h8F;
            8'h5E: rom_lookup = 8'hBF;
            8'h5F: rom_lookup = 8'hAF;
            8'h60: rom_lookup = 8'h5C;
            8'h61: rom_lookup = 8'h4C;
            8'h62: rom_lookup = 8'h7C;
            8'h63: rom_lookup = 8'h6C;
            8'h64: rom_lookup = 8'h1C;
            8'h65: rom_lookup = 8'h0C;
            8'h66: rom_lookup = 8'h3C;
            8'h67: rom_lookup = 8'h2C;
            8'h68: rom_lookup = 8'hDC;
            8'h69: rom_lookup = 8'hCC;
            8'h6A: rom_lookup = 8'hFC;
            8'h6B: rom_lookup = 8'hEC;
            8'h6C: rom_lookup = 8'h9C;
            8'h6D: rom_lookup = 8'h8C;
            8'h6E: rom_lookup = 8'hBC;
            8'h6F: rom_lookup = 8'hAC;
            8'h70: rom_lookup = 8'h5D;
            8'h71: rom_lookup = 8'h4D;
            8'h72: rom_lookup = 8'h7D;
            8'h73: rom_lookup = 8'h6D;
            8'h74: rom_lookup = 8'h1D;
            8'h75: rom_lookup = 8'h0D;
            8'h76: rom_lookup = 8'h3D;
            8'h77: rom_lookup = 8'h2D;
            8'h78: rom_lookup = 8'hDD;
            8'h79: rom_lookup = 8'hCD;
            8'h7A: rom_lookup = 8'hFD;
            8'h7B: rom_lookup = 8'hED;
            8'h7C: rom_lookup = 8'h9D;
            8'h7D: rom_lookup = 8'h8D;
            8'h7E: rom_lookup = 8'hBD;
            8'h7F: rom_lookup = 8'hAD;
            8'h80: rom_lookup = 8'h52;
            8'h81: rom_lookup = 8'h42;
            8'h82: rom_lookup = 8'h72;
            8'h83: rom_lookup = 8'h62;
            8'h84: rom_lookup = 8'h12;
            8'h85: rom_lookup = 8'h02;
            8'h86: rom_lookup = 8'h32;
            8'h87: rom_lookup = 8'h22;
            8'h88: rom_lookup = 8'hD2;
            8'h89: rom_lookup = 8'hC2;
            8'h8A: rom_lookup = 8'hF2;
            8'h8B: rom_lookup = 8'hE2;
            8'h8C: rom_lookup = 8'h92;
            8'h8D: rom_lookup = 8'h82;
            8'h8E: rom_lookup = 8'hB2;
            8'h8F: rom_lookup = 8'hA2;
            8'h90: rom_lookup = 8'h53;
            8'h91: rom_lookup = 8'h43;
            8'h92: rom_lookup = 8'h73;
            8'h93: rom_lookup = 8'h63;
            8'h94: rom_lookup = 8'h13;
            8'h95: rom_lookup = 8'h03;
            8'h96: rom_lookup = 8'h33;
            8'h97: rom_lookup = 8'h23;
            8'h98: rom_lookup = 8'hD3;
            8'h99: rom_lookup = 8'hC3;
            8'h9A: rom_lookup = 8'hF3;
            8'h9B: rom_lookup = 8'hE3;
            8'h9C: rom_lookup = 8'h93;
            8'h9D: rom_lookup = 8'h83;
            8'h9E: rom_lookup = 8'hB3;
            8'h9F: rom_lookup = 8'hA3;
            8'hA0: rom_lookup = 8'h50;
            8'hA1: rom_lookup = 8'h40;
            8'hA2: rom_lookup = 8'h70;
            8'hA3: rom_lookup = 8'h60;
            8'hA4: rom_lookup = 8'h10;
            8'hA5: rom_lookup = 8'h00;
            8'hA6: rom_lookup = 8'h30;
            8'hA7: rom_lookup = 8'h20;
            8'hA8: rom_lookup = 8'hD0;
            8'hA9: rom_lookup = 8'hC0;
            8'hAA: rom_lookup = 8'hF0;
            8'hAB: rom_lookup = 8'hE0;
            8'hAC: rom_lookup = 8'h90;
            8'hAD: rom_lookup = 8'h80;
            8'hAE: rom_lookup = 8'hB0;
            8'hAF: rom_lookup = 8'hA0;
            8'hB0: rom_lookup = 8'h51;
            8'hB1: rom_lookup = 8'h41;
            8'hB2: rom_lookup = 8'h71;
            8'hB3: rom_lookup = 8'h61;
            8'hB4: rom_lookup = 8'h11;
            8'hB5: rom_lookup = 8'h01;
            8'hB6: rom_lookup = 8'h31;
            8'hB7: rom_lookup = 8'h21;
            8'hB8: rom_lookup = 8'hD1;
            8'hB9: rom_lookup = 8'hC1;
            8'hBA: rom_lookup = 8'hF1;
            8'hBB: rom_lookup = 8'hE1;
            8'hBC: rom_lookup = 8'h91;
            8'hBD: rom_lookup = 8'h81;
            8'hBE: rom_lookup = 8'hB1;
            8'hBF: rom_lookup = 8'hA1;
            8'hC0: rom_lookup = 8'h56;
            8'hC1: rom_lookup = 8'h46;
            8'hC2: rom_lookup = 8'h76;
            8'hC3: rom_lookup = 8'h66;
            8'hC4: rom_lookup = 8'h16;
            8'hC5: rom_lookup = 8'h06;
            8'hC6: rom_lookup = 8'h36;
            8'hC7: rom_lookup = 8'h26;
            8'hC8: rom_lookup = 8'hD6;
            8'hC9: rom_lookup = 8'hC6;
            8'hCA: rom_lookup = 8'hF6;
            8'hCB: rom_lookup = 8'hE6;
            8'hCC: rom_lookup = 8'h96;
            8'hCD: rom_lookup = 8'h86;
            8'hCE: rom_lookup = 8'hB6;
            8'hCF: rom_lookup = 8'hA6;
            8'hD0: rom_lookup = 8'h57;
            8'hD1: rom_lookup = 8'h47;
            8'hD2: rom_lookup = 8'h77;
            8'hD3: rom_lookup = 8'h67;
            8'hD4: rom_lookup = 8'h17;
            8'hD5: rom_lookup = 8'h07;
            8'hD6: rom_lookup = 8'h37;
            8'hD7: rom_lookup = 8'h27;
            8'hD8: rom_lookup = 8'hD7;
            8'hD9: rom_lookup = 8'hC7;
            8'hDA: rom_lookup = 8'hF7;
            8'hDB: rom_lookup = 8'hE7;
            8'hDC: rom_lookup = 8'h97;
            8'hDD: rom_lookup = 8'h87;
            8'hDE: rom_lookup = 8'hB7;
            8'hDF: rom_lookup = 8'hA7;
            8'hE0: rom_lookup = 8'h54;
            8'hE1: rom_lookup = 8'h44;
            8'hE2: rom_lookup = 8'h74;
            8'hE3: rom_lookup = 8'h64;
            8'hE4: rom_lookup = 8'h14;
            8'hE5: rom_lookup = 8'h04;
            8'hE6: rom_lookup = 8'h34;
            8'hE7: rom_lookup = 8'h24;
            8'hE8: rom_lookup = 8'hD4;
            8'hE9: rom_lookup = 8'hC4;
            8'hEA: rom_lookup = 8'hF4;
            8'hEB: rom_lookup = 8'hE4;
            8'hEC: rom_lookup = 8'h94;
            8'hED: rom_lookup = 8'h84;
            8'hEE: rom_lookup = 8'hB4;
            8'hEF: rom_lookup = 8'hA4;
            8'hF0: rom_lookup = 8'h55;
            8'hF1: rom_lookup = 8'h45;
            8'hF2: rom_lookup = 8'h75;
            8'hF3: rom_lookup = 8'h65;
            8'hF4: rom_lookup = 8'h15;
            8'hF5: rom_lookup = 8'h05;
            8'hF6: rom_lookup = 8'h35;
            8'hF7: rom_lookup = 8'h25;
            8'hF8: rom_lookup = 8'hD5;
            8'hF9: rom_lookup = 8'hC5;
            8'hFA: rom_lookup = 8'hF5;
            8'hFB: rom_lookup = 8'hE5;
            8'hFC: rom_lookup = 8'h95;
            8'hFD: rom_lookup = 8'h85;
            8'hFE: rom_lookup = 8'hB5;
            8'hFF: rom_lookup = 8'hA5;
            default: rom_lookup = 8'h00;
        endcase
    endfunction

    always_comb begin
        rom_d = rom_lookup(Address);
    end

    // Output register: the only state; reset clears it, the table itself is constant.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            out_q <= 8'h00;
        end else begin
            out_q <= rom_d;
        end
    end

    assign Out = out_q;

endmodule

// File: tb/tb_rom.sv
// Bench for the 256 x 8 registered ROM: reset behaviour, latency, sweeps and random reads
// compared against the nibble-swap/XOR contents formula.
module tb_rom;

    logic       Clock;
    logic       Reset_n;
    logic [7:0] Address;
    logic [7:0] Out;

    int n_checks;
    int n_fail;

    rom dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .Address (Address),
        .Out     (Out)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [7:0] model(input int a);
        logic [7:0] av;
        av = a[7:0];
        return {av[3:0], av[7:4]} ^ 8'h5A;
    endfunction

    task automatic test_reset();
        Reset_n = 1'b0;
        Address = 8'h05;
        #1;
        n_checks++;
        if (Out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_async got=%h want=%h", Out, 8'h00);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge Clock); #1;
            n_checks++;
            if (Out !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d got=%h want=%h", i, Out, 8'h00);
            end
        end
        @(negedge Clock);
        Reset_n = 1'b1;
        #1;
        n_checks++;
        if (Out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_release_pre_edge got=%h want=%h", Out, 8'h00);
        end
        @(posedge Clock); #1;
        n_checks++;
        if (Out !== 8'h0A) begin
            n_fail++;
            $display("FAIL reset_first_edge got=%h want=%h", Out, 8'h0A);
        end
    endtask

    task automatic test_sweep();
        logic [7:0] ref_vals [6];
        ref_vals = '{8'h5A, 8'h4A, 8'h7A, 8'h6A, 8'h1A, 8'h0A};
        for (int a = 0; a < 6; a++) begin
            @(negedge Clock);
            Address = a[7:0];
            for (int c = 0; c < 10; c++) begin
                @(posedge Clock); #1;
                n_checks++;
                if (Out !== ref_vals[a]) begin
                    n_fail++;
                    $display("FAIL sweep addr=%0d cyc=%0d got=%h want=%h", a, c, Out, ref_vals[a]);
                end
            end
        end
    endtask

    task automatic test_latency();
        @(negedge Clock);
        Address = 8'h00;
        @(posedge Clock); #1;
        n_checks++;
        if (Out !== 8'h5A) begin
            n_fail++;
            $display("FAIL latency_before got=%h want=%h", Out, 8'h5A);
        end
        @(negedge Clock);
        Address = 8'hFF;
        #2;
        n_checks++;
        if (Out !== 8'h5A) begin
            n_fail++;
            $display("FAIL latency_mid_cycle got=%h want=%h", Out, 8'h5A);
        end
        @(posedge Clock); #1;
        n_checks++;
        if (Out !== 8'hA5) begin
            n_fail++;
            $display("FAIL latency_after got=%h want=%h", Out, 8'hA5);
        end
    endtask

    task automatic test_exhaustive();
        logic [7:0] prev;
        prev = Out;
        for (int a = 0; a < 256; a++) begin
            @(negedge Clock);
            Address = a[7:0];
            #1;
            n_checks++;
            if (Out !== prev) begin
                n_fail++;
                $display("FAIL exh_comb addr=%h got=%h want=%h", a[7:0], Out, prev);
            end
            @(posedge Clock); #1;
            n_checks++;
            if (Out !== model(a)) begin
                n_fail++;
                $display("FAIL exh_data addr=%h got=%h want=%h", a[7:0], Out, model(a));
            end
            prev = model(a);
        end
    endtask

    task automatic test_reference_points();
        logic [7:0] addrs [9];
        logic [7:0] vals  [9];
        addrs = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h12, 8'hA5, 8'hFF};
        vals  = '{8'h5A, 8'h4A, 8'h7A, 8'h6A, 8'h1A, 8'h0A, 8'h7B, 8'h00, 8'hA5};
        for (int i = 0; i < 9; i++) begin
            @(negedge Clock);
            Address = addrs[i];
            @(posedge Clock); #1;
            n_checks++;
            if (Out !== vals[i]) begin
                n_fail++;
                $display("FAIL refpoint addr=%h got=%h want=%h", addrs[i], Out, vals[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        @(negedge Clock);
        Address = 8'h12;
        @(posedge Clock); #1;
        n_checks++;
        if (Out !== 8'h7B) begin
            n_fail++;
            $display("FAIL midrst_before got=%h want=%h", Out, 8'h7B);
        end
        #1;
        Reset_n = 1'b0;
        #1;
        n_checks++;
        if (Out !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_async got=%h want=%h", Out, 8'h00);
        end
        #1;
        Reset_n = 1'b1;
        #1;
        n_checks++;
        if (Out !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_released got=%h want=%h", Out, 8'h00);
        end
        @(posedge Clock); #1;
        n_checks++;
        if (Out !== 8'h7B) begin
            n_fail++;
            $display("FAIL midrst_reload got=%h want=%h", Out, 8'h7B);
        end
    endtask

    task automatic test_random();
        int a;
        for (int i = 0; i < 300; i++) begin
            @(negedge Clock);
            a = int'($urandom_range(0, 255));
            Address = a[7:0];
            @(posedge Clock); #1;
            n_checks++;
            if (Out !== model(a)) begin
                n_fail++;
                $display("FAIL random addr=%h got=%h want=%h", a[7:0], Out, model(a));
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        Reset_n  = 1'b1;
        Address  = 8'h00;
        test_reset();
        test_sweep();
        test_latency();
        test_reference_points();
        test_exhaustive();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
